// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: one-hot T1..T6 ring plus opcode decode
// driving the 12-bit control word; free-run, single-step and halt.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] ir_opcode,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       pc_increment,
  output logic       pc_enable,
  output logic       mar_load_n,
  output logic       ram_enable_n,
  output logic       ir_load_n,
  output logic       ir_enable_n,
  output logic       a_load_n,
  output logic       a_enable,
  output logic       alu_subtract,
  output logic       alu_enable,
  output logic       b_load_n,
  output logic       out_load_n
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } cw_t;

  localparam cw_t CW_NOP = '{
    cp:   1'b0,
    ep:   1'b0,
    lm_n: 1'b1,
    ce_n: 1'b1,
    li_n: 1'b1,
    ei_n: 1'b1,
    la_n: 1'b1,
    ea:   1'b0,
    su:   1'b0,
    eu:   1'b0,
    lb_n: 1'b1,
    lo_n: 1'b1
  };

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    step_q;
  logic    step_rise;
  logic    advance;
  logic    active;
  logic    is_lda, is_add, is_sub, is_out, is_hlt;
  cw_t     cw;

  assign step_rise = step & ~step_q;
  assign advance   = ~halted_q & (run | step_rise);
  // Word is gated by clear_n too so it reads NOP for the whole reset window.
  assign active    = advance & clear_n;

  assign is_lda = (ir_opcode == OP_LDA);
  assign is_add = (ir_opcode == OP_ADD);
  assign is_sub = (ir_opcode == OP_SUB);
  assign is_out = (ir_opcode == OP_OUT);
  assign is_hlt = (ir_opcode == OP_HLT);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      step_q   <= step;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (advance) begin
      unique case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (is_hlt) halted_d = 1'b1;
          else        state_d  = T5;
        end
        T5: state_d = T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  always_comb begin
    cw = CW_NOP;
    if (active) begin
      unique case (state_q)
        T1: begin
          cw.ep   = 1'b1;
          cw.lm_n = 1'b0;
        end
        T2: cw.cp = 1'b1;
        T3: begin
          cw.ce_n = 1'b0;
          cw.li_n = 1'b0;
        end
        T4: begin
          unique case (1'b1)
            is_lda, is_add, is_sub: begin
              cw.ei_n = 1'b0;
              cw.lm_n = 1'b0;
            end
            is_out: begin
              cw.ea   = 1'b1;
              cw.lo_n = 1'b0;
            end
            default: cw = CW_NOP;
          endcase
        end
        T5: begin
          unique case (1'b1)
            is_lda: begin
              cw.ce_n = 1'b0;
              cw.la_n = 1'b0;
            end
            is_add, is_sub: begin
              cw.ce_n = 1'b0;
              cw.lb_n = 1'b0;
            end
            default: cw = CW_NOP;
          endcase
        end
        T6: begin
          unique case (1'b1)
            is_add, is_sub: begin
              cw.eu   = 1'b1;
              cw.la_n = 1'b0;
              cw.su   = is_sub;
            end
            default: cw = CW_NOP;
          endcase
        end
        default: cw = CW_NOP;
      endcase
    end
  end

  assign t_state      = state_q;
  assign halted       = halted_q;
  assign pc_increment = cw.cp;
  assign pc_enable    = cw.ep;
  assign mar_load_n   = cw.lm_n;
  assign ram_enable_n = cw.ce_n;
  assign ir_load_n    = cw.li_n;
  assign ir_enable_n  = cw.ei_n;
  assign a_load_n     = cw.la_n;
  assign a_enable     = cw.ea;
  assign alu_subtract = cw.su;
  assign alu_enable   = cw.eu;
  assign b_load_n     = cw.lb_n;
  assign out_load_n   = cw.lo_n;

endmodule
